// File: rtl/ov7670_vga_reader.sv
// ov7670_vga_reader: scans the 320x240 12-bit frame buffer out as 640x480@60 VGA with 2x2 pixel doubling.
// Defining OV7670_VGA_TESTPAT_EN adds a testpat input that replaces visible pixels with 8 vertical colour bars.
module ov7670_vga_reader #(
  parameter int unsigned c_img_cols    = 320,
  parameter int unsigned c_img_rows    = 240,
  parameter int unsigned c_nb_img_pxls = 17,
  parameter int unsigned c_nb_buf      = 12,
  parameter int unsigned c_clk_div     = 4,
  parameter int unsigned c_h_vis       = 640,
  parameter int unsigned c_h_fp        = 16,
  parameter int unsigned c_h_sync      = 96,
  parameter int unsigned c_h_bp        = 48,
  parameter int unsigned c_v_vis       = 480,
  parameter int unsigned c_v_fp        = 10,
  parameter int unsigned c_v_sync      = 2,
  parameter int unsigned c_v_bp        = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rgbmode,
`ifdef OV7670_VGA_TESTPAT_EN
  input  logic                     testpat,
`endif
  output logic [c_nb_img_pxls-1:0] frame_addr,
  input  logic [c_nb_buf-1:0]      frame_data,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic [3:0]               vga_r,
  output logic [3:0]               vga_g,
  output logic [3:0]               vga_b,
  output logic                     frame_start
);

  localparam int unsigned c_h_tot  = c_h_vis + c_h_fp + c_h_sync + c_h_bp;
  localparam int unsigned c_v_tot  = c_v_vis + c_v_fp + c_v_sync + c_v_bp;
  localparam int unsigned c_nb_h   = $clog2(c_h_tot);
  localparam int unsigned c_nb_v   = $clog2(c_v_tot);
  localparam int unsigned c_nb_div = $clog2(c_clk_div);
  localparam int unsigned c_hs_beg = c_h_vis + c_h_fp;
  localparam int unsigned c_hs_end = c_hs_beg + c_h_sync;
  localparam int unsigned c_vs_beg = c_v_vis + c_v_fp;
  localparam int unsigned c_vs_end = c_vs_beg + c_v_sync;
  localparam int unsigned c_last_inc_line = 2 * c_img_rows - 1;
`ifdef OV7670_VGA_TESTPAT_EN
  localparam int unsigned c_bar_w  = c_h_vis / 8;
`endif

  logic [c_nb_div-1:0]      div_cnt;
  logic [c_nb_h-1:0]        h_cnt;
  logic [c_nb_v-1:0]        v_cnt;
  logic [c_nb_img_pxls-1:0] line_base;

  logic                     tick_c;
  logic                     h_wrap_c;
  logic                     v_wrap_c;
  logic [c_nb_h-1:0]        h_nxt_c;
  logic [c_nb_v-1:0]        v_nxt_c;
  logic [c_nb_img_pxls-1:0] base_nxt_c;
  logic [c_nb_img_pxls-1:0] addr_nxt_c;
  logic                     vis_c;
  logic                     vis_nxt_c;
  logic [3:0]               pix_r_c;
  logic [3:0]               pix_g_c;
  logic [3:0]               pix_b_c;
`ifdef OV7670_VGA_TESTPAT_EN
  logic [2:0]               bar_c;
`endif

  // Next scan position and the buffer address of the pixel shown after the coming tick
  always_comb begin
    tick_c     = (div_cnt == c_nb_div'(c_clk_div - 1));
    h_wrap_c   = (h_cnt == c_nb_h'(c_h_tot - 1));
    v_wrap_c   = (v_cnt == c_nb_v'(c_v_tot - 1));
    h_nxt_c    = h_wrap_c ? '0 : h_cnt + c_nb_h'(1);
    v_nxt_c    = v_cnt;
    base_nxt_c = line_base;
    if (h_wrap_c) begin
      v_nxt_c = v_wrap_c ? '0 : v_cnt + c_nb_v'(1);
      // Each stored row is shown on two lines; advance after the second (odd) one
      if (v_wrap_c)
        base_nxt_c = '0;
      else if (v_cnt[0] && (v_cnt < c_nb_v'(c_last_inc_line)))
        base_nxt_c = line_base + c_nb_img_pxls'(c_img_cols);
    end
    vis_nxt_c  = (h_nxt_c < c_nb_h'(c_h_vis)) && (v_nxt_c < c_nb_v'(c_v_vis));
    addr_nxt_c = vis_nxt_c ? base_nxt_c + c_nb_img_pxls'(h_nxt_c >> 1) : base_nxt_c;
    vis_c      = (h_cnt < c_nb_h'(c_h_vis)) && (v_cnt < c_nb_v'(c_v_vis));
  end

  // Pixel colour for the current position; blanking forces black
  always_comb begin
    pix_r_c = '0;
    pix_g_c = '0;
    pix_b_c = '0;
`ifdef OV7670_VGA_TESTPAT_EN
    bar_c   = 3'(h_cnt / c_nb_h'(c_bar_w));
`endif
    if (vis_c) begin
      if (rgbmode) begin
        pix_r_c = frame_data[11:8];
        pix_g_c = frame_data[7:4];
        pix_b_c = frame_data[3:0];
      end else begin
        pix_r_c = frame_data[7:4];
        pix_g_c = frame_data[7:4];
        pix_b_c = frame_data[7:4];
      end
`ifdef OV7670_VGA_TESTPAT_EN
      if (testpat) begin
        pix_r_c = {4{bar_c[2]}};
        pix_g_c = {4{bar_c[1]}};
        pix_b_c = {4{bar_c[0]}};
      end
`endif
    end
  end

  // Counters, address and the one-pixel-delayed output stage, all advanced on the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_base   <= '0;
      frame_addr  <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      div_cnt     <= tick_c ? '0 : div_cnt + c_nb_div'(1);
      if (tick_c) begin
        h_cnt       <= h_nxt_c;
        v_cnt       <= v_nxt_c;
        line_base   <= base_nxt_c;
        frame_addr  <= addr_nxt_c;
        de          <= vis_c;
        hsync       <= !((h_cnt >= c_nb_h'(c_hs_beg)) && (h_cnt < c_nb_h'(c_hs_end)));
        vsync       <= !((v_cnt >= c_nb_v'(c_vs_beg)) && (v_cnt < c_nb_v'(c_vs_end)));
        vga_r       <= pix_r_c;
        vga_g       <= pix_g_c;
        vga_b       <= pix_b_c;
        frame_start <= h_wrap_c && v_wrap_c;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_vga_reader.sv
// Bench for ov7670_vga_reader: a shrunken-timing instance over many frames plus a default-timing instance
// over its first lines, both checked every clock against an arithmetic model of the scan.
module tb_ov7670_vga_reader;

  localparam int DIV = 4;
  localparam int NS  = 48;

  typedef struct packed {
    int ht; int vt; int hv; int vv; int hs0; int hs1; int vs0; int vs1; int cols;
  } cfg_t;

  typedef struct packed {
    logic [16:0] addr;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic        fs;
  } exp_t;

  localparam cfg_t CS = '{ht:24, vt:17, hv:16, vv:12, hs0:18, hs1:21, vs0:13, vs1:15, cols:8};
  localparam cfg_t CF = '{ht:800, vt:525, hv:640, vv:480, hs0:656, hs1:752, vs0:490, vs1:492, cols:320};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rgbmode = 1'b0;
  logic        tp = 1'b0;
`ifdef OV7670_VGA_TESTPAT_EN
  logic        testpat = 1'b0;
`endif
  logic [16:0] addr_s, addr_f;
  logic [11:0] fd_s, fd_f;
  logic        hs_s, vs_s, de_s, fs_s, hs_f, vs_f, de_f, fs_f;
  logic [3:0]  r_s, g_s, b_s, r_f, g_f, b_f;

  logic [11:0] mem_s [0:NS-1];
  int          cyc = 0;
  logic        mode_tick = 1'b0;
  logic        tp_tick = 1'b0;
  int          chk_en = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ov7670_vga_reader #(
    .c_img_cols(8), .c_img_rows(6), .c_clk_div(DIV),
    .c_h_vis(16), .c_h_fp(2), .c_h_sync(3), .c_h_bp(3),
    .c_v_vis(12), .c_v_fp(1), .c_v_sync(2), .c_v_bp(2)
  ) dut_s (
    .clk(clk), .rst(rst), .rgbmode(rgbmode),
`ifdef OV7670_VGA_TESTPAT_EN
    .testpat(testpat),
`endif
    .frame_addr(addr_s), .frame_data(fd_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .frame_start(fs_s)
  );

  ov7670_vga_reader dut_f (
    .clk(clk), .rst(rst), .rgbmode(rgbmode),
`ifdef OV7670_VGA_TESTPAT_EN
    .testpat(testpat),
`endif
    .frame_addr(addr_f), .frame_data(fd_f),
    .hsync(hs_f), .vsync(vs_f), .de(de_f),
    .vga_r(r_f), .vga_g(g_f), .vga_b(b_f), .frame_start(fs_f)
  );

  // Synchronous-read buffers: small one holds random words, full one returns its own address
  always @(posedge clk) begin
    fd_s <= (int'(addr_s) < NS) ? mem_s[int'(addr_s)] : 12'hxxx;
    fd_f <= addr_f[11:0];
  end

  // Clocks since reset release, and the mode inputs as seen at the latest tick edge
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else begin
      cyc <= cyc + 1;
      if ((cyc + 1) % DIV == 0) begin
        mode_tick <= rgbmode;
        tp_tick   <= tp;
      end
    end
  end

  // Stored pixel index for screen position (h,v); blanking holds the current row base
  function automatic int pix_addr(input cfg_t c, input int h, input int v);
    int base;
    base = (v < c.vv) ? (v / 2) * c.cols : (c.vv / 2 - 1) * c.cols;
    return (h < c.hv && v < c.vv) ? base + h / 2 : base;
  endfunction

  function automatic exp_t model(input cfg_t c, input int n, input logic mode, input logic tpat, input bit full);
    exp_t e;
    int j, h, v, bar;
    logic [11:0] d;
    e = '{addr:17'd0, hs:1'b1, vs:1'b1, de:1'b0, rgb:12'h000, fs:1'b0};
    j = n / DIV;
    if (j == 0) return e;
    e.addr = 17'(pix_addr(c, j % c.ht, (j / c.ht) % c.vt));
    h = (j - 1) % c.ht;
    v = ((j - 1) / c.ht) % c.vt;
    e.de = (h < c.hv) && (v < c.vv);
    e.hs = !(h >= c.hs0 && h < c.hs1);
    e.vs = !(v >= c.vs0 && v < c.vs1);
    if (e.de) begin
      d = full ? 12'(pix_addr(c, h, v)) : mem_s[pix_addr(c, h, v)];
      e.rgb = mode ? d : {d[7:4], d[7:4], d[7:4]};
      if (tpat) begin
        bar = h / (c.hv / 8);
        e.rgb = {((bar & 4) != 0) ? 4'hF : 4'h0, ((bar & 2) != 0) ? 4'hF : 4'h0,
                 ((bar & 1) != 0) ? 4'hF : 4'h0};
      end
    end
    e.fs = (n % DIV == 0) && (j % (c.ht * c.vt) == 0);
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s at clk %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  task automatic check(input string tag, input exp_t o, input exp_t e);
    cmp({tag, "_addr"}, 32'(o.addr), 32'(e.addr));
    cmp({tag, "_sync_de"}, 32'({o.hs, o.vs, o.de}), 32'({e.hs, e.vs, e.de}));
    cmp({tag, "_rgb"}, 32'(o.rgb), 32'(e.rgb));
    cmp({tag, "_frame_start"}, 32'(o.fs), 32'(e.fs));
  endtask

  always @(negedge clk) begin
    if (chk_en != 0) begin
      check("small", '{addr:addr_s, hs:hs_s, vs:vs_s, de:de_s, rgb:{r_s, g_s, b_s}, fs:fs_s},
            model(CS, cyc, mode_tick, tp_tick, 1'b0));
      check("full", '{addr:addr_f, hs:hs_f, vs:vs_f, de:de_f, rgb:{r_f, g_f, b_f}, fs:fs_f},
            model(CF, cyc, mode_tick, tp_tick, 1'b1));
    end
  end

  task automatic run(input int n, input bit rnd_mode, input bit rnd_tp);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_mode) rgbmode = 1'($urandom_range(0, 1));
      if (rnd_tp && ($urandom_range(0, 15) == 0)) tp = ~tp;
`ifdef OV7670_VGA_TESTPAT_EN
      testpat = tp;
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) mem_s[i] = 12'($urandom);
    mem_s[5] = 12'hA5C;
    mem_s[9] = 12'h0B7;
    rst = 1'b1;
    @(posedge clk);
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rgbmode = 1'b1;
    run(1700, 1'b0, 1'b0);
    rgbmode = 1'b0;
    run(1700, 1'b0, 1'b0);
    run(3300, 1'b1, 1'b0);
    // Reset again at an arbitrary point mid-line
    run(int'($urandom_range(1, 7)), 1'b1, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
`ifdef OV7670_VGA_TESTPAT_EN
    tp = 1'b1;
    testpat = 1'b1;
    run(1700, 1'b1, 1'b0);
    run(2000, 1'b1, 1'b1);
    tp = 1'b0;
    testpat = 1'b0;
    run(3300, 1'b1, 1'b0);
`else
    run(7000, 1'b1, 1'b0);
`endif
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
